// File: rtl/bnn_pkg.sv
// Shared types and default sizing for the BNN sequencer slice.
package bnn_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    HIDDEN = 2'd1,
    OUTPUT = 2'd2,
    DONE   = 2'd3
  } bnn_state_t;

  localparam int BNN_N_IN    = 16;
  localparam int BNN_N_HID   = 8;
  localparam int BNN_N_OUT   = 4;
  localparam int BNN_PCW     = 5;
  localparam int BNN_HID_THR = 8;

  // Index width that never collapses to zero bits for tiny counts.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bnn_seq_ctrl_if.sv
// Pin-side byte stream, datapath request/ack and result bundle.
//
// Handshakes: a feature byte transfers on a clock edge where in_valid and
// in_ready are both high. A datapath request holds dp_req, dp_layer, dp_idx
// and dp_vec stable until the edge where dp_ack is high; that edge consumes
// dp_sum and completes the neuron. dp_ack with dp_req low is ignored.
interface bnn_seq_ctrl_if
  import bnn_pkg::*;
#(
  parameter int N_IN  = BNN_N_IN,
  parameter int N_HID = BNN_N_HID,
  parameter int N_OUT = BNN_N_OUT,
  parameter int PCW   = BNN_PCW
);
  localparam int IDXW = clog2_min1(max_int(N_HID, N_OUT));
  localparam int CLSW = clog2_min1(N_OUT);

  logic            in_valid;
  logic [7:0]      in_data;
  logic            in_ready;
  logic            dp_req;
  logic            dp_layer;
  logic [IDXW-1:0] dp_idx;
  logic [N_IN-1:0] dp_vec;
  logic            dp_ack;
  logic [PCW-1:0]  dp_sum;
  logic            busy;
  logic            res_valid;
  logic [CLSW-1:0] res_class;
  logic [PCW-1:0]  res_score;

  // Sequencer side.
  modport master (
    input  in_valid, in_data, dp_ack, dp_sum,
    output in_ready, dp_req, dp_layer, dp_idx, dp_vec,
           busy, res_valid, res_class, res_score
  );

  // Pins / datapath side.
  modport slave (
    output in_valid, in_data, dp_ack, dp_sum,
    input  in_ready, dp_req, dp_layer, dp_idx, dp_vec,
           busy, res_valid, res_class, res_score
  );

endinterface

// File: rtl/bnn_argmax.sv
// Running maximum with index; strict-greater update keeps the lowest index on ties.
module bnn_argmax #(
  parameter int PCW  = 5,
  parameter int CLSW = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            upd,
  input  logic            first,
  input  logic [CLSW-1:0] idx,
  input  logic [PCW-1:0]  sum,
  output logic [PCW-1:0]  best,
  output logic [CLSW-1:0] bidx
);

  // First candidate always loads; later ones only when strictly larger.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best <= '0;
      bidx <= '0;
    end else if (clr) begin
      best <= '0;
      bidx <= '0;
    end else if (upd && (first || (sum > best))) begin
      best <= sum;
      bidx <= idx;
    end
  end

endmodule

// File: rtl/bnn_seq_ctrl.sv
// Sequencer: byte load, hidden-layer sweep, output-layer sweep with argmax, result hold.
module bnn_seq_ctrl
  import bnn_pkg::*;
#(
  parameter int N_IN    = BNN_N_IN,
  parameter int N_HID   = BNN_N_HID,
  parameter int N_OUT   = BNN_N_OUT,
  parameter int PCW     = BNN_PCW,
  parameter int HID_THR = BNN_HID_THR
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  bnn_seq_ctrl_if.master bus,
  output bnn_state_t   dbg_state
);

  localparam int NBYTES = N_IN / 8;
  localparam int BCW    = clog2_min1(NBYTES);
  localparam int IDXW   = clog2_min1(max_int(N_HID, N_OUT));
  localparam int CLSW   = clog2_min1(N_OUT);

  bnn_state_t      state;
  logic [BCW-1:0]  byte_cnt;
  logic [IDXW-1:0] idx;
  logic [N_IN-1:0] vec;
  logic [N_HID-1:0] hid;
  logic            out_upd;

  assign out_upd = (state == OUTPUT) && bus.dp_ack;

  // Sequencing FSM; clr overrides everything but leaves vec/hid/result intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LOAD;
      byte_cnt <= '0;
      idx      <= '0;
      vec      <= '0;
      hid      <= '0;
    end else if (clr) begin
      state    <= LOAD;
      byte_cnt <= '0;
      idx      <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (bus.in_valid) begin
            vec[{byte_cnt, 3'b000} +: 8] <= bus.in_data;
            if (byte_cnt == BCW'(NBYTES - 1)) begin
              byte_cnt <= '0;
              idx      <= '0;
              state    <= HIDDEN;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        HIDDEN: begin
          if (bus.dp_ack) begin
            hid[idx] <= (bus.dp_sum >= PCW'(HID_THR));
            if (idx == IDXW'(N_HID - 1)) begin
              idx   <= '0;
              state <= OUTPUT;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        OUTPUT: begin
          if (bus.dp_ack) begin
            if (idx == IDXW'(N_OUT - 1)) begin
              idx   <= '0;
              state <= DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        DONE: begin
          // A byte here is byte 0 of the next frame.
          if (bus.in_valid) begin
            vec[7:0] <= bus.in_data;
            if (NBYTES == 1) begin
              byte_cnt <= '0;
              idx      <= '0;
              state    <= HIDDEN;
            end else begin
              byte_cnt <= BCW'(1);
              state    <= LOAD;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Result registers persist across clr, so the argmax clear is unused here.
  bnn_argmax #(
    .PCW  (PCW),
    .CLSW (CLSW)
  ) u_argmax (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .upd   (out_upd),
    .first (idx == '0),
    .idx   (idx[CLSW-1:0]),
    .sum   (bus.dp_sum),
    .best  (bus.res_score),
    .bidx  (bus.res_class)
  );

  // Outputs decoded from state and held registers only.
  assign bus.in_ready  = (state == LOAD) || (state == DONE);
  assign bus.dp_req    = (state == HIDDEN) || (state == OUTPUT);
  assign bus.busy      = (state == HIDDEN) || (state == OUTPUT);
  assign bus.dp_layer  = (state == OUTPUT);
  assign bus.dp_idx    = idx;
  assign bus.dp_vec    = (state == OUTPUT) ? N_IN'(hid) : vec;
  assign bus.res_valid = (state == DONE);
  assign dbg_state     = state;

endmodule

// File: tb/tb_bnn_seq_ctrl.sv
// Self-checking bench for bnn_seq_ctrl with a behavioural datapath responder.
module tb_bnn_seq_ctrl;
  import bnn_pkg::*;

  localparam int NB = BNN_N_IN / 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic clr;
  bnn_state_t dbg_state;

  always #5 clk = ~clk;

  bnn_seq_ctrl_if bus ();

  bnn_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- frame model / scoreboard ----------------
  logic [7:0]  frame_bytes [NB];
  int          hid_sums [BNN_N_HID];
  int          out_sums [BNN_N_OUT];
  logic [15:0] cur_vec;
  logic [7:0]  exp_hid;
  logic [31:0] exp_q [$];

  int checks = 0;
  int errors = 0;
  int stall  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected hidden bits and argmax straight from the frame's sums.
  task automatic setup_frame(input bit push);
    int mx;
    int cls;
    cur_vec = '0;
    for (int b = 0; b < NB; b++) cur_vec[b*8 +: 8] = frame_bytes[b];
    for (int i = 0; i < BNN_N_HID; i++) exp_hid[i] = (hid_sums[i] >= BNN_HID_THR);
    mx = -1;
    foreach (out_sums[i]) if (out_sums[i] > mx) mx = out_sums[i];
    cls = -1;
    foreach (out_sums[i]) if (cls < 0 && out_sums[i] == mx) cls = i;
    if (push) exp_q.push_back({16'(cls), 16'(mx)});
  endtask

  task automatic rand_frame();
    for (int b = 0; b < NB; b++) frame_bytes[b] = 8'($urandom_range(0, 255));
    foreach (hid_sums[i]) hid_sums[i] = $urandom_range(0, 16);
    foreach (out_sums[i]) out_sums[i] = $urandom_range(0, 16);
  endtask

  // ---------------- datapath responder ----------------
  int          wait_cnt = 0;
  bit          waiting  = 0;
  logic [31:0] prev_idx;
  logic        prev_layer;

  always @(negedge clk) begin
    logic [15:0] exp_vec;
    int i;
    if (bus.dp_req) begin
      i = int'(bus.dp_idx);
      check("in_ready_busy", 32'(bus.in_ready), 32'd0);
      exp_vec = bus.dp_layer ? {8'h00, exp_hid} : cur_vec;
      check("dp_vec", 32'(bus.dp_vec), 32'(exp_vec));
      if (waiting) begin
        check("idx_hold", 32'(bus.dp_idx), prev_idx);
        check("layer_hold", 32'(bus.dp_layer), 32'(prev_layer));
      end
      prev_idx   = 32'(bus.dp_idx);
      prev_layer = bus.dp_layer;
      if (wait_cnt >= stall) begin
        bus.dp_ack = 1'b1;
        if (bus.dp_layer) bus.dp_sum = (i < BNN_N_OUT) ? 5'(out_sums[i]) : 5'd0;
        else              bus.dp_sum = 5'(hid_sums[i]);
        wait_cnt = 0;
        waiting  = 0;
      end else begin
        bus.dp_ack = 1'b0;
        bus.dp_sum = 5'($urandom_range(0, 31));
        wait_cnt++;
        waiting = 1;
      end
    end else begin
      bus.dp_ack = 1'b0;
      wait_cnt   = 0;
      waiting    = 0;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic send_byte(input logic [7:0] b);
    check("in_ready_load", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom_range(0, 255));
  endtask

  task automatic send_frame(input bit from_done);
    for (int b = 0; b < NB; b++) begin
      send_byte(frame_bytes[b]);
      if (b == 0 && from_done) check("res_valid_fall", 32'(bus.res_valid), 32'd0);
    end
  endtask

  // Full frame: load, sweep, then latency and result against the scoreboard.
  task automatic run_frame(input int stall_v, input bit from_done);
    int n;
    logic [31:0] e;
    stall = stall_v;
    setup_frame(1'b1);
    send_frame(from_done);
    n = 1;
    while (!bus.res_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'(1 + (BNN_N_HID + BNN_N_OUT) * (stall_v + 1)));
    e = exp_q.pop_front();
    check("res_valid", 32'(bus.res_valid), 32'd1);
    check("res_class", 32'(bus.res_class), 32'(e[31:16]));
    check("res_score", 32'(bus.res_score), 32'(e[15:0]));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
    check({tag, "_dp_req"},    32'(bus.dp_req),    32'd0);
    check({tag, "_dp_layer"},  32'(bus.dp_layer),  32'd0);
    check({tag, "_dp_idx"},    32'(bus.dp_idx),    32'd0);
    check({tag, "_dp_vec"},    32'(bus.dp_vec),    32'd0);
    check({tag, "_busy"},      32'(bus.busy),      32'd0);
    check({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
    check({tag, "_res_class"}, 32'(bus.res_class), 32'd0);
    check({tag, "_res_score"}, 32'(bus.res_score), 32'd0);
    check({tag, "_state"},     32'(dbg_state),     32'(LOAD));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    bit found;
    rst_n        = 1'b0;
    clr          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.dp_ack   = 1'b0;
    bus.dp_sum   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");

    // Directed frame with instant ack.
    frame_bytes[0] = 8'hA5;
    frame_bytes[1] = 8'h3C;
    hid_sums = '{8, 7, 9, 0, 16, 8, 3, 8};
    out_sums = '{2, 6, 6, 1};
    run_frame(0, 1'b0);
    check("directed_class", 32'(bus.res_class), 32'd1);
    check("directed_score", 32'(bus.res_score), 32'd6);

    // Same frame, ack every third cycle.
    run_frame(2, 1'b1);

    // All output sums tie.
    rand_frame();
    out_sums = '{4, 4, 4, 4};
    run_frame(0, 1'b1);
    check("tie_class", 32'(bus.res_class), 32'd0);
    check("tie_score", 32'(bus.res_score), 32'd4);

    // Abort during hidden neuron 3.
    rand_frame();
    stall = 0;
    setup_frame(1'b0);
    send_frame(1'b1);
    found = 0;
    n = 0;
    while (!found && n < 50) begin
      if (bus.dp_req && !bus.dp_layer && bus.dp_idx == 3) found = 1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    check("abort_reach_idx3", 32'(found), 32'd1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("abort_dp_req", 32'(bus.dp_req), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_res_valid", 32'(bus.res_valid), 32'd0);
    check("abort_state", 32'(dbg_state), 32'(LOAD));
    rand_frame();
    run_frame(0, 1'b0);

    // Randomized back-to-back frames with random stalls.
    for (int f = 0; f < 8; f++) begin
      rand_frame();
      if (f == 3) out_sums[1] = out_sums[3];
      run_frame($urandom_range(0, 2), 1'b1);
    end

    // Asynchronous reset during the output layer.
    rand_frame();
    stall = 1;
    setup_frame(1'b0);
    send_frame(1'b1);
    found = 0;
    n = 0;
    while (!found && n < 100) begin
      if (bus.dp_layer) found = 1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    check("reset_reach_output", 32'(found), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rand_frame();
    run_frame(0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bnn_seq_ctrl.md
# bnn_seq_ctrl

Sequencer for the microgreen BNN datapath in `tt_um_microgreen_bnn`. It collects a binarized feature vector byte-by-byte from the pin interface, then steps the shared XNOR-popcount unit through every hidden neuron and every output neuron, one request per neuron. It binarizes hidden sums against a threshold, performs argmax over output sums and presents the winning class. The popcount datapath is external; this block owns only sequencing, activation storage and the result.

## Interface
Parameters:
- `N_IN`, 16: input feature bits; must be a multiple of 8.
- `N_HID`, 8: hidden neurons; `N_HID <= N_IN`.
- `N_OUT`, 4: output classes.
- `PCW`, 5: popcount width; must hold `N_IN`.
- `HID_THR`, 8: hidden activation threshold.

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `clr`, in, 1: synchronous abort to LOAD.
- `in_valid`, in, 1: feature byte valid.
- `in_data`, in, 8: feature byte, LSB-first packing.
- `in_ready`, out, 1: byte accepted when `in_valid && in_ready`.
- `dp_req`, out, 1: datapath request.
- `dp_layer`, out, 1: 0 = hidden, 1 = output.
- `dp_idx`, out, `$clog2(max(N_HID,N_OUT))`: neuron index.
- `dp_vec`, out, `N_IN`: activation vector. Hidden layer: input vector. Output layer: hidden bits, zero-extended.
- `dp_ack`, in, 1: datapath completion.
- `dp_sum`, in, `PCW`: popcount, valid when `dp_ack`.
- `busy`, out, 1: high in HIDDEN/OUTPUT.
- `res_valid`, out, 1: result valid.
- `res_class`, out, `$clog2(N_OUT)`: argmax index.
- `res_score`, out, `PCW`: winning sum.

## Operation
States:
- **LOAD**: `in_ready=1`.
  - Accepted byte k is written to `vec[8k+7:8k]`; the byte counter increments.
  - Acceptance of byte `N_IN/8-1` moves to HIDDEN with idx=0.
- **HIDDEN**: `dp_req=1`, `dp_layer=0`, `dp_idx=idx`.
  - On `dp_ack`: `hid[idx] <= (dp_sum >= HID_THR)`.
  - If `idx == N_HID-1`: idx <= 0, go to OUTPUT; else idx++.
- **OUTPUT**: `dp_req=1`, `dp_layer=1`.
  - On `dp_ack`: if idx==0 or `dp_sum > best`, then `best <= dp_sum`, `bidx <= idx`. Strict `>` means ties keep the lowest index.
  - Last idx goes to DONE.
- **DONE**: `res_valid=1`, `in_ready=1`.
  - `res_class` and `res_score` hold `bidx` and `best`.
  - An accepted byte clears `res_valid`, writes byte 0, and enters LOAD with counter=1.

General rules:
- `dp_req` stays high and `dp_idx`, `dp_layer`, `dp_vec` stay stable until `dp_ack`. A datapath that acks in the same cycle completes one neuron per cycle.
- `dp_ack` while `dp_req=0` is ignored.
- `clr` wins over every other event:
  - next state LOAD; byte counter, idx and `res_valid` are cleared;
  - `dp_req` drops the next cycle;
  - `vec`, `hid` and result registers keep their values.
- `in_valid` outside LOAD/DONE is not accepted (`in_ready=0`).

## Timing
- Reset values:
  - state LOAD, all counters 0, `vec`/`hid` 0;
  - `in_ready=1`, `dp_req=0`, `dp_layer=0`, `dp_idx=0`, `dp_vec=0`;
  - `busy=0`, `res_valid=0`, `res_class=0`, `res_score=0`.
- All outputs are registered or decoded directly from the state register. No combinational path from `dp_ack`/`dp_sum` to outputs.
- Load to first request: `dp_req` is high the cycle after the last byte is accepted.
- With `dp_ack` tied high: `N_HID + N_OUT` request cycles, then `res_valid` in the cycle after the final ack. With defaults, 12 cycles after the last byte, `res_valid` rises on cycle 13.
- Each additional wait cycle on `dp_ack` adds exactly one cycle.
- Reset asserted mid-run returns every output to its reset value immediately (asynchronously).

## Structure
- `bnn_pkg` holds:
  - the state enum `bnn_state_t` {LOAD, HIDDEN, OUTPUT, DONE};
  - default constants `BNN_N_IN`, `BNN_N_HID`, `BNN_N_OUT`, `BNN_PCW`, `BNN_HID_THR`.
- One sub-module, `bnn_argmax`: running max/index register with a `first` input, strict-greater update and a synchronous clear.
- The top-level wrapper connects `ui_in`/`uio_in`/`uo_out` to this block. No pin mapping lives here.

## Test plan
- **Load + instant ack:** bytes 0xA5, 0x3C; `dp_ack=1`; hidden sums 8,7,9,0,16,8,3,8; output sums 2,6,6,1.
  - `dp_vec=16'h3CA5` during HIDDEN.
  - `hid=8'b1011_0101`.
  - `res_class=1`, `res_score=6`; `res_valid` rises 13 cycles after the second byte.
- **Stalled ack:** ack only every 3rd cycle.
  - `dp_idx`/`dp_vec` stable while waiting.
  - Total latency is 36 cycles + 1.
- **Ties:** all output sums equal 4 → `res_class=0`, `res_score=4`.
- **Abort:** `clr` during HIDDEN idx=3.
  - `dp_req` is low the next cycle, `in_ready=1`, `res_valid=0`.
  - A new two-byte load then runs to a correct result.
- **Reset:** `rst_n` low during OUTPUT → all outputs at reset values immediately.
- **Back-to-back:** in DONE, send the next frame's byte 0.
  - `res_valid` falls the next cycle.
  - The second result is correct and independent of the first.
